sys_timer_master: RTL and testbench

Avalon-MM master that programs and services the interval-timer slave on the system bus. On host command, it loads a 32-bit period and starts the timer in continuous mode with interrupts enabled. On every timer irq it clears the status register and counts the tick. Optionally, it snapshots the residual count to measure irq service latency. It sits between acquisition-control logic and the 16-bit timer register file (0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h).

---
 rtl/sys_timer_pkg.sv | 27 ++
 rtl/timer_avmm_xact.sv | 41 ++++
 rtl/sys_timer_master.sv | 164 ++++++++++++++++
 tb/tb_sys_timer_master.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_timer_pkg.sv
// Shared constants for the interval-timer master: register map, control bits,
// sequencer states and the fallback period.
package sys_timer_pkg;

  localparam logic [2:0] TMR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_PERIOD_H = 3'd3;
  localparam logic [2:0] TMR_SNAP_L   = 3'd4;
  localparam logic [2:0] TMR_SNAP_H   = 3'd5;

  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  localparam logic [15:0] CTRL_GO   = 16'(1 << ITO) | 16'(1 << CONT) | 16'(1 << START);
  localparam logic [15:0] CTRL_HALT = 16'(1 << STOP);

  localparam logic [31:0] DEFAULT_PERIOD = 32'd1999999;

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, GUARD,
    SNAP_WR, RD_L, RD_H, RD_WAIT, STOP_WR
  } state_e;

endpackage

// File: rtl/timer_avmm_xact.sv
// Single-transaction Avalon-MM engine: presents the held request on the bus,
// acknowledges on acceptance and flags read data one cycle later.
module timer_avmm_xact #(
  parameter bit READ_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_write,
  input  logic [2:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        ack,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic        read_n,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  input  logic        waitrequest
);

  // The requester holds req and its fields until ack, so the bus stays
  // stable through waitrequest without any local holding register.
  assign chipselect = req;
  assign write_n    = !(req && req_write);
  assign read_n     = READ_EN ? !(req && !req_write) : 1'b1;
  assign address    = req ? req_addr : 3'd0;
  assign writedata  = (req && req_write) ? req_wdata : 16'd0;
  assign ack        = req && !waitrequest;
  assign rd_data    = READ_EN ? readdata : 16'd0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_valid <= 1'b0;
    else          rd_valid <= ack && !req_write && READ_EN;
  end

endmodule

// File: rtl/sys_timer_master.sv
// Programs and services the interval timer; define TIMER_SNAPSHOT_EN to add
// residual-count snapshots after each serviced irq.
module sys_timer_master #(
  parameter logic [31:0] DEFAULT_PERIOD = sys_timer_pkg::DEFAULT_PERIOD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [31:0] cfg_period,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic        read_n,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  input  logic        waitrequest,
  input  logic        irq,
  output logic        busy,
  output logic        running,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snapshot_valid
);
  import sys_timer_pkg::*;

`ifdef TIMER_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] period_q;
  logic        req, req_write, ack, rd_valid, start_take;
  logic [2:0]  req_addr;
  logic [15:0] req_wdata, rd_data, snap_lo;
  logic [31:0] snap_q;
  logic        snap_pulse;

  timer_avmm_xact #(.READ_EN(SNAP_EN)) u_xact (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ack        (ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .waitrequest(waitrequest)
  );

  // Stop wins over start in RUN; anything arriving mid-sequence is dropped.
  assign start_take = cfg_start && ((state_q == IDLE) || (state_q == RUN && !cfg_stop));

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    req_write = 1'b1;
    req_addr  = TMR_STATUS;
    req_wdata = 16'd0;
    case (state_q)
      IDLE: if (start_take) state_d = WR_PL;
      RUN: begin
        if (cfg_stop)        state_d = STOP_WR;
        else if (start_take) state_d = WR_PL;
        else if (irq)        state_d = CLR_ST;
      end
      // Period writes force-stop the slave, so control goes last.
      WR_PL: begin
        req = 1'b1; req_addr = TMR_PERIOD_L; req_wdata = period_q[15:0];
        if (ack) state_d = WR_PH;
      end
      WR_PH: begin
        req = 1'b1; req_addr = TMR_PERIOD_H; req_wdata = period_q[31:16];
        if (ack) state_d = WR_CTRL;
      end
      WR_CTRL: begin
        req = 1'b1; req_addr = TMR_CONTROL; req_wdata = CTRL_GO;
        if (ack) state_d = RUN;
      end
      CLR_ST: begin
        req = 1'b1; req_addr = TMR_STATUS;
        if (ack) state_d = GUARD;
      end
      GUARD: state_d = SNAP_EN ? SNAP_WR : RUN;
      SNAP_WR: begin
        req = 1'b1; req_addr = TMR_SNAP_L;
        if (ack) state_d = RD_L;
      end
      RD_L: begin
        req = 1'b1; req_write = 1'b0; req_addr = TMR_SNAP_L;
        if (ack) state_d = RD_H;
      end
      RD_H: begin
        req = 1'b1; req_write = 1'b0; req_addr = TMR_SNAP_H;
        if (ack) state_d = RD_WAIT;
      end
      RD_WAIT: if (rd_valid) state_d = RUN;
      STOP_WR: begin
        req = 1'b1; req_addr = TMR_CONTROL; req_wdata = CTRL_HALT;
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      period_q   <= 32'd0;
      running    <= 1'b0;
      tick       <= 1'b0;
      tick_count <= 32'd0;
    end else begin
      state_q <= state_d;
      tick    <= 1'b0;
      if (start_take) period_q <= (cfg_period == 32'd0) ? DEFAULT_PERIOD : cfg_period;
      if (ack) begin
        case (state_q)
          WR_CTRL: begin running <= 1'b1; tick_count <= 32'd0; end
          CLR_ST:  begin tick <= 1'b1; tick_count <= tick_count + 32'd1; end
          STOP_WR: running <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Low half arrives while the high read is still pending; the high half
  // arrives in RD_WAIT and completes the snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo    <= 16'd0;
      snap_q     <= 32'd0;
      snap_pulse <= 1'b0;
    end else begin
      snap_pulse <= 1'b0;
      if (rd_valid) begin
        if (state_q == RD_WAIT) begin
          snap_q     <= {rd_data, snap_lo};
          snap_pulse <= 1'b1;
        end else begin
          snap_lo <= rd_data;
        end
      end
    end
  end

  assign busy           = !(state_q == IDLE || state_q == RUN);
  assign snapshot       = SNAP_EN ? snap_q : 32'd0;
  assign snapshot_valid = SNAP_EN ? snap_pulse : 1'b0;

endmodule

// File: tb/tb_sys_timer_master.sv
// Directed bench for sys_timer_master with a behavioural timer slave and a
// transaction-level expectation queue checked every cycle.
module tb_sys_timer_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic [2:0]  address;
  logic        chipselect, write_n, read_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        waitrequest = 1'b0;
  logic        irq;
  logic        busy, running, tick, snapshot_valid;
  logic [31:0] tick_count, snapshot;

  logic        irq_set = 1'b0, irq_clr = 1'b0, mon_en = 1'b0;
  int          n_total = 0, n_pass = 0;

  typedef struct packed { logic [2:0] addr; logic wr; logic [15:0] data; } xact_t;
  xact_t exp_q[$];

  always #5 clk = ~clk;

  sys_timer_master dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_period(cfg_period), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .irq(irq), .busy(busy), .running(running),
    .tick(tick), .tick_count(tick_count), .snapshot(snapshot),
    .snapshot_valid(snapshot_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Timer slave: down-counter with irq on wrap, status write clears irq.
  logic        slv_run;
  logic [31:0] slv_cnt, slv_per, snap_reg;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0; slv_run <= 1'b0; slv_cnt <= 32'd0; slv_per <= 32'd0;
      snap_reg <= 32'd0; readdata <= 16'd0;
    end else begin
      if (slv_run) begin
        if (slv_cnt == 32'd0) begin irq <= 1'b1; slv_cnt <= slv_per; end
        else slv_cnt <= slv_cnt - 32'd1;
      end
      if (irq_set) irq <= 1'b1;
      if (irq_clr) irq <= 1'b0;
      if (chipselect && !waitrequest) begin
        if (!write_n) begin
          case (address)
            3'd0: irq <= 1'b0;
            3'd1: begin
              if (writedata[2]) begin slv_run <= 1'b1; slv_cnt <= slv_per; end
              if (writedata[3]) slv_run <= 1'b0;
            end
            3'd2: begin slv_per[15:0] <= writedata; slv_run <= 1'b0; end
            3'd3: begin slv_per[31:16] <= writedata; slv_run <= 1'b0; end
            3'd4: snap_reg <= 32'h0000_0007;
            default: ;
          endcase
        end else if (!read_n) begin
          readdata <= (address == 3'd4) ? snap_reg[15:0] :
                      (address == 3'd5) ? snap_reg[31:16] : 16'd0;
        end
      end
    end
  end

  // Transaction-level model and per-cycle compare.
  logic        m_tick, m_running, stalled;
  logic [31:0] m_count;
  logic [2:0]  h_addr;
  logic [15:0] h_data;
  int          snap_pulses;
  xact_t       e;
  always @(negedge clk) begin
    if (!reset_n) begin
      m_tick = 1'b0; m_running = 1'b0; m_count = 32'd0; stalled = 1'b0; snap_pulses = 0;
    end else if (mon_en) begin
      check("tick", 32'(tick), 32'(m_tick));
      check("tick_count", tick_count, m_count);
      check("running", 32'(running), 32'(m_running));
      check("strobes", 32'(chipselect ? (write_n != read_n) : (write_n && read_n)), 32'd1);
      if (stalled && chipselect) begin
        check("hold_addr", 32'(address), 32'(h_addr));
        check("hold_data", 32'(writedata), 32'(h_data));
      end
`ifdef TIMER_SNAPSHOT_EN
      if (snapshot_valid) begin
        snap_pulses++;
        check("snapshot", snapshot, 32'h0000_0007);
      end
`else
      check("snapshot_tied", {snapshot[30:0], snapshot_valid}, 32'd0);
      check("read_n_tied", 32'(read_n), 32'd1);
`endif
      stalled = chipselect && waitrequest;
      h_addr  = address;
      h_data  = writedata;
      m_tick  = 1'b0;
      if (chipselect && !waitrequest) begin
        check("xact_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("xact_addr", 32'(address), 32'(e.addr));
          check("xact_rw", 32'(!write_n), 32'(e.wr));
          if (e.wr) check("xact_data", 32'(writedata), 32'(e.data));
        end
        if (!write_n && address == 3'd0) begin m_tick = 1'b1; m_count = m_count + 32'd1; end
        if (!write_n && address == 3'd1 && writedata == 16'h0007) begin
          m_running = 1'b1; m_count = 32'd0;
        end
        if (!write_n && address == 3'd1 && writedata == 16'h0008) m_running = 1'b0;
      end
    end
  end

  task automatic push(input logic [2:0] a, input logic w, input logic [15:0] d);
    exp_q.push_back('{addr: a, wr: w, data: d});
  endtask

  task automatic push_svc();
    push(3'd0, 1'b1, 16'h0000);
`ifdef TIMER_SNAPSHOT_EN
    push(3'd4, 1'b1, 16'h0000);
    push(3'd4, 1'b0, 16'h0000);
    push(3'd5, 1'b0, 16'h0000);
`endif
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic start_cmd(input logic [31:0] per);
    cfg_period = per; cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
  endtask

  task automatic stop_cmd();
    cfg_stop = 1'b1;
    cycle();
    cfg_stop = 1'b0;
    check("stop_addr", 32'(address), 32'd1);
    check("stop_data", 32'(writedata), 32'h0008);
    cycle();
    check("stopped", 32'(running), 32'd0);
    check("stop_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 20 && !(running && !busy); i++) cycle();
    check("run_reached", 32'(running && !busy), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) cycle();
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic queue_done();
    repeat (2) cycle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", 32'(chipselect), 32'd0);
    check("rst_write_n", 32'(write_n), 32'd1);
    check("rst_read_n", 32'(read_n), 32'd1);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_wdata", 32'(writedata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_count", tick_count, 32'd0);
    check("rst_snap", snapshot, 32'd0);
    check("rst_snap_v", 32'(snapshot_valid), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    cycle();

    // cfg_stop and irq in IDLE do nothing
    cfg_stop = 1'b1; irq_set = 1'b1;
    cycle();
    cfg_stop = 1'b0; irq_set = 1'b0;
    repeat (4) cycle();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cs", 32'(chipselect), 32'd0);
    irq_clr = 1'b1; cycle(); irq_clr = 1'b0;

    // Start sequence, zero wait states
    push(3'd2, 1'b1, 16'h0005); push(3'd3, 1'b1, 16'h0001); push(3'd1, 1'b1, 16'h0007);
    start_cmd(32'h0001_0005);
    check("s1_cs", 32'(chipselect), 32'd1);
    check("s1_addr", 32'(address), 32'd2);
    check("s1_data", 32'(writedata), 32'h0005);
    check("s1_busy", 32'(busy), 32'd1);
    cycle();
    check("s2_addr", 32'(address), 32'd3);
    check("s2_data", 32'(writedata), 32'h0001);
    cycle();
    check("s3_addr", 32'(address), 32'd1);
    check("s3_data", 32'(writedata), 32'h0007);
    check("s3_not_running", 32'(running), 32'd0);
    cycle();
    check("s4_running", 32'(running), 32'd1);
    check("s4_cs", 32'(chipselect), 32'd0);
    push(3'd1, 1'b1, 16'h0008);
    stop_cmd();
    queue_done();

    // Waitrequest during WR_PH, plus a start that must be dropped
    push(3'd2, 1'b1, 16'h0005); push(3'd3, 1'b1, 16'h0001); push(3'd1, 1'b1, 16'h0007);
    start_cmd(32'h0001_0005);
    cycle();
    waitrequest = 1'b1; cfg_period = 32'h1234_5678; cfg_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("wr_hold_addr", 32'(address), 32'd3);
      check("wr_hold_data", 32'(writedata), 32'h0001);
      cycle();
      cfg_start = 1'b0;
    end
    waitrequest = 1'b0;
    check("wr_rel_addr", 32'(address), 32'd3);
    cycle();
    check("wr_ctrl_addr", 32'(address), 32'd1);
    cycle();
    check("wr_running", 32'(running), 32'd1);
    push(3'd1, 1'b1, 16'h0008);
    stop_cmd();
    queue_done();

    // Period 10: five irqs serviced once each
    push(3'd2, 1'b1, 16'h000A); push(3'd3, 1'b1, 16'h0000); push(3'd1, 1'b1, 16'h0007);
    repeat (5) push_svc();
    start_cmd(32'd10);
    wait_run();
    for (int i = 0; i < 400 && tick_count < 32'd5; i++) cycle();
    check("five_ticks", tick_count, 32'd5);
    wait_idle();
    push(3'd1, 1'b1, 16'h0008);
    stop_cmd();
    check("five_ticks_kept", tick_count, 32'd5);
`ifdef TIMER_SNAPSHOT_EN
    check("snap_pulses", 32'(snap_pulses), 32'd5);
    check("snap_value", snapshot, 32'h0000_0007);
`endif
    queue_done();

    // cfg_stop and irq in the same RUN cycle
    push(3'd2, 1'b1, 16'h03E8); push(3'd3, 1'b1, 16'h0000); push(3'd1, 1'b1, 16'h0007);
    push(3'd1, 1'b1, 16'h0008);
    start_cmd(32'd1000);
    wait_run();
    irq_set = 1'b1;
    cycle();
    irq_set = 1'b0; cfg_stop = 1'b1;
    cycle();
    cfg_stop = 1'b0;
    check("si_addr", 32'(address), 32'd1);
    check("si_data", 32'(writedata), 32'h0008);
    cycle();
    check("si_running", 32'(running), 32'd0);
    repeat (5) cycle();
    check("si_no_tick", tick_count, 32'd0);
    check("si_cs", 32'(chipselect), 32'd0);
    irq_clr = 1'b1; cycle(); irq_clr = 1'b0;
    queue_done();

    // Zero period falls back to the default; irq service latency
    push(3'd2, 1'b1, 16'h847F); push(3'd3, 1'b1, 16'h001E); push(3'd1, 1'b1, 16'h0007);
    start_cmd(32'd0);
    wait_run();
    push_svc();
    irq_set = 1'b1;
    cycle();
    irq_set = 1'b0;
    cycle();
    check("lat_cs", 32'(chipselect), 32'd1);
    check("lat_addr", 32'(address), 32'd0);
    check("lat_write_n", 32'(write_n), 32'd0);
    check("lat_tick_lo", 32'(tick), 32'd0);
    cycle();
    check("lat_tick_hi", 32'(tick), 32'd1);
    check("lat_count", tick_count, 32'd1);
    cycle();
    check("lat_tick_end", 32'(tick), 32'd0);
    wait_idle();
    push(3'd1, 1'b1, 16'h0008);
    stop_cmd();
`ifdef TIMER_SNAPSHOT_EN
    check("snap_pulses_total", 32'(snap_pulses), 32'd6);
`endif
    queue_done();

    // Asynchronous reset releases a stalled bus at once
    waitrequest = 1'b1;
    start_cmd(32'd5);
    check("ar_cs_before", 32'(chipselect), 32'd1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("ar_cs", 32'(chipselect), 32'd0);
    check("ar_write_n", 32'(write_n), 32'd1);
    check("ar_busy", 32'(busy), 32'd0);
    exp_q.delete();
    cycle();
    reset_n = 1'b1; waitrequest = 1'b0;
    repeat (2) cycle();
    check("ar_idle_cs", 32'(chipselect), 32'd0);
    check("ar_running", 32'(running), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
